// File: rtl/alto_task_sequencer.sv
// alto_task_sequencer
//   Microcode task sequencer. Holds the microprogram counter for every task.
//   Each step it forms the next fetch address as NEXT | modifiers, arbitrates
//   device wakeups by fixed priority, and performs the task switch one
//   instruction after the TASK F1 that requested it.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous reset, active high
//   step_i         current microinstruction completes this cycle
//   next_i         NEXT field of the current microinstruction
//   modifiers_i    branch modifiers, ORed into next_i
//   task_f1_i      current microinstruction carries F1=TASK
//   block_i        current microinstruction carries BLOCK
//   wakeup_i       device wakeup requests, one bit per task
//   ucode_addr_o   registered control-store fetch address
//   task_o         task owning the microinstruction at ucode_addr_o
//   next_task_o    task chosen at the last TASK (valid while armed_o)
//   armed_o        switch pending; it takes effect on the next step
//   switch_count_o (ALTO_TASK_STATS_EN only) count of real task switches
//
// Configuration
//   ALTO_TASK_STATS_EN  adds switch_count_o and its 16-bit wrapping counter.

module alto_task_sequencer #(
  parameter int unsigned TASKS = 16,
  parameter int unsigned UPC_W = 10,
  parameter int unsigned TID_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic [UPC_W-1:0] next_i,
  input  logic [UPC_W-1:0] modifiers_i,
  input  logic             task_f1_i,
  input  logic             block_i,
  input  logic [TASKS-1:0] wakeup_i,
  output logic [UPC_W-1:0] ucode_addr_o,
  output logic [TID_W-1:0] task_o,
  output logic [TID_W-1:0] next_task_o,
`ifdef ALTO_TASK_STATS_EN
  output logic [15:0]      switch_count_o,
`endif
  output logic             armed_o
);

  logic [UPC_W-1:0] ucode_addr_q, ucode_addr_d;
  logic [TID_W-1:0] task_q, task_d;
  logic [TID_W-1:0] next_task_q, next_task_d;
  logic             armed_q, armed_d;
  logic [UPC_W-1:0] upc_q [TASKS];
  logic [TASKS-1:0] wake_pend_q, wake_pend_d;

  logic [UPC_W-1:0] addr;
  logic [TASKS-1:0] blk_clr;
  logic [TASKS-1:0] pend_eff;
  logic [TID_W-1:0] winner;
  logic             upc_we;
  logic             do_switch;

  assign addr = next_i | modifiers_i;

  // BLOCK retires the current task's wakeup; the emulator can never block.
  always_comb begin
    blk_clr = '0;
    if (step_i && block_i && (task_q != '0)) begin
      blk_clr[task_q] = 1'b1;
    end
  end

  // Clear beats a same-cycle wakeup for the blocking task.
  assign wake_pend_d = (wake_pend_q | wakeup_i) & ~blk_clr;

  // Arbitration sees this cycle's BLOCK clear; task 0 is always runnable.
  always_comb begin
    pend_eff    = wake_pend_q & ~blk_clr;
    pend_eff[0] = 1'b1;
    winner      = '0;
    for (int unsigned i = 0; i < TASKS; i++) begin
      if (pend_eff[i]) begin
        winner = TID_W'(i);
      end
    end
  end

  always_comb begin
    ucode_addr_d = ucode_addr_q;
    task_d       = task_q;
    next_task_d  = next_task_q;
    armed_d      = armed_q;
    upc_we       = 1'b0;
    do_switch    = 1'b0;
    if (step_i) begin
      upc_we = 1'b1;
      if (armed_q) begin
        // Instruction after the TASK: hand the fetch over to the chosen task.
        task_d    = next_task_q;
        armed_d   = 1'b0;
        do_switch = (next_task_q != task_q);
        // Same task: the saved upc is being written this step, so bypass it.
        ucode_addr_d = do_switch ? upc_q[next_task_q] : addr;
      end else begin
        ucode_addr_d = addr;
      end
      if (task_f1_i) begin
        next_task_d = winner;
        armed_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ucode_addr_q <= '0;
      task_q       <= '0;
      next_task_q  <= '0;
      armed_q      <= 1'b0;
      wake_pend_q  <= '0;
      for (int unsigned i = 0; i < TASKS; i++) begin
        upc_q[i] <= '0;
      end
    end else begin
      ucode_addr_q <= ucode_addr_d;
      task_q       <= task_d;
      next_task_q  <= next_task_d;
      armed_q      <= armed_d;
      wake_pend_q  <= wake_pend_d;
      if (upc_we) begin
        upc_q[task_q] <= addr;
      end
    end
  end

`ifdef ALTO_TASK_STATS_EN
  logic [15:0] switch_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      switch_count_q <= '0;
    end else if (do_switch) begin
      switch_count_q <= switch_count_q + 16'd1;
    end
  end

  assign switch_count_o = switch_count_q;
`endif

  assign ucode_addr_o = ucode_addr_q;
  assign task_o       = task_q;
  assign next_task_o  = next_task_q;
  assign armed_o      = armed_q;

endmodule

// File: tb/tb_alto_task_sequencer.sv
// Directed testbench for alto_task_sequencer. Expected values are worked out
// by hand from the sequencing rules: OR-formed addresses, one-instruction
// switch delay, fixed-priority wakeup arbitration and saved per-task upcs.

module tb_alto_task_sequencer;

  localparam int unsigned TASKS = 16;
  localparam int unsigned UPC_W = 10;
  localparam int unsigned TID_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             step_i;
  logic [UPC_W-1:0] next_i;
  logic [UPC_W-1:0] modifiers_i;
  logic             task_f1_i;
  logic             block_i;
  logic [TASKS-1:0] wakeup_i;
  logic [UPC_W-1:0] ucode_addr_o;
  logic [TID_W-1:0] task_o;
  logic [TID_W-1:0] next_task_o;
  logic             armed_o;
`ifdef ALTO_TASK_STATS_EN
  logic [15:0]      switch_count_o;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alto_task_sequencer #(
    .TASKS (TASKS),
    .UPC_W (UPC_W),
    .TID_W (TID_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .step_i       (step_i),
    .next_i       (next_i),
    .modifiers_i  (modifiers_i),
    .task_f1_i    (task_f1_i),
    .block_i      (block_i),
    .wakeup_i     (wakeup_i),
    .ucode_addr_o (ucode_addr_o),
    .task_o       (task_o),
    .next_task_o  (next_task_o),
`ifdef ALTO_TASK_STATS_EN
    .switch_count_o (switch_count_o),
`endif
    .armed_o      (armed_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One completed microinstruction; outputs are sampled 1 time unit after the edge.
  task automatic do_step(input logic [UPC_W-1:0] nxt, input logic [UPC_W-1:0] mods,
                         input logic f1, input logic blk);
    next_i      = nxt;
    modifiers_i = mods;
    task_f1_i   = f1;
    block_i     = blk;
    step_i      = 1'b1;
    @(posedge clk_i);
    #1;
    step_i    = 1'b0;
    task_f1_i = 1'b0;
    block_i   = 1'b0;
  endtask

  task automatic pulse_wake(input int unsigned idx);
    wakeup_i      = '0;
    wakeup_i[idx] = 1'b1;
    @(posedge clk_i);
    #1;
    wakeup_i = '0;
  endtask

  task automatic check_state(input string tag, input logic [UPC_W-1:0] addr,
                             input logic [TID_W-1:0] tsk, input logic arm);
    check_eq({tag, "_addr"}, 32'(ucode_addr_o), 32'(addr));
    check_eq({tag, "_task"}, 32'(task_o), 32'(tsk));
    check_eq({tag, "_armed"}, 32'(armed_o), 32'(arm));
  endtask

  initial begin
    rst_i       = 1'b1;
    step_i      = 1'b0;
    next_i      = '0;
    modifiers_i = '0;
    task_f1_i   = 1'b0;
    block_i     = 1'b0;
    wakeup_i    = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_state("reset", 10'h000, 4'd0, 1'b0);
    check_eq("reset_next_task", 32'(next_task_o), 32'd0);
`ifdef ALTO_TASK_STATS_EN
    check_eq("reset_count", 32'(switch_count_o), 32'd0);
`endif
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Address formation is a plain OR, including overlapping bits.
    do_step(10'h010, 10'h001, 1'b0, 1'b0);
    check_state("or_basic", 10'h011, 4'd0, 1'b0);
    do_step(10'h0F0, 10'h033, 1'b0, 1'b0);
    check_state("or_overlap", 10'h0F3, 4'd0, 1'b0);

    // No step: state holds even with new inputs presented.
    next_i = 10'h3FF;
    repeat (2) @(posedge clk_i);
    #1;
    check_state("hold", 10'h0F3, 4'd0, 1'b0);

    // Wake 4, TASK, then switch; task 4 starts at its saved upc 0.
    pulse_wake(4);
    do_step(10'h020, 10'h000, 1'b1, 1'b0);
    check_state("arm4", 10'h020, 4'd0, 1'b1);
    check_eq("arm4_next", 32'(next_task_o), 32'd4);
    do_step(10'h030, 10'h000, 1'b0, 1'b0);
    check_state("sw4", 10'h000, 4'd4, 1'b0);

    // Wake 9 with 4 still pending: highest index wins.
    pulse_wake(9);
    do_step(10'h040, 10'h000, 1'b1, 1'b0);
    check_eq("arm9_next", 32'(next_task_o), 32'd9);
    do_step(10'h050, 10'h000, 1'b0, 1'b0);
    check_state("sw9", 10'h000, 4'd9, 1'b0);

    // Task 9 blocks with TASK: its own clear applies, so 4 wins.
    do_step(10'h100, 10'h000, 1'b1, 1'b1);
    check_eq("blk9_next", 32'(next_task_o), 32'd4);
    do_step(10'h110, 10'h000, 1'b0, 1'b0);
    check_state("back4", 10'h050, 4'd4, 1'b0);

    // Task 4 blocks; nothing else pending, so emulator resumes at 0x030.
    do_step(10'h060, 10'h000, 1'b1, 1'b1);
    check_eq("blk4_next", 32'(next_task_o), 32'd0);
    do_step(10'h070, 10'h000, 1'b0, 1'b0);
    check_state("back0", 10'h030, 4'd0, 1'b0);

    // BLOCK in task 0 is ignored; wake 7 arrives in the same cycle as the block.
    wakeup_i = 16'h0080;
    do_step(10'h080, 10'h000, 1'b0, 1'b1);
    wakeup_i = '0;
    check_state("blk0", 10'h080, 4'd0, 1'b0);

    // Back-to-back TASK: switch to 7 and re-arm toward 7 (still pending).
    do_step(10'h200, 10'h000, 1'b1, 1'b0);
    check_eq("b2b_arm_next", 32'(next_task_o), 32'd7);
    do_step(10'h210, 10'h000, 1'b1, 1'b0);
    check_state("b2b_sw", 10'h000, 4'd7, 1'b1);
    check_eq("b2b_rearm_next", 32'(next_task_o), 32'd7);
    // Switch to the same task: bypass delivers this step's address.
    do_step(10'h220, 10'h000, 1'b0, 1'b0);
    check_state("bypass", 10'h220, 4'd7, 1'b0);
`ifdef ALTO_TASK_STATS_EN
    check_eq("count", 32'(switch_count_o), 32'd5);
`endif

    // Asynchronous reset while armed takes effect before the next edge.
    do_step(10'h300, 10'h000, 1'b1, 1'b0);
    check_eq("pre_rst_armed", 32'(armed_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_state("async_rst", 10'h000, 4'd0, 1'b0);
`ifdef ALTO_TASK_STATS_EN
    check_eq("rst_count", 32'(switch_count_o), 32'd0);
`endif
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Pending switch was aborted and wake 7 was forgotten.
    do_step(10'h400, 10'h000, 1'b1, 1'b0);
    check_state("post_rst", 10'h400, 4'd0, 1'b1);
    check_eq("post_rst_next", 32'(next_task_o), 32'd0);
    do_step(10'h410, 10'h000, 1'b0, 1'b0);
    check_state("post_rst_same", 10'h410, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
